// File: rtl/prng_arb_pkg.sv
// Shared definitions for the PRNG arbiter: draw FSM states, register map of the
// xorshift PRNG slave and constant OBI request fields.
package prng_arb_pkg;

  // One state per phase of a draw: trigger write, its response, data read,
  // its response, and the single-cycle delivery to the winning requester.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    TRIG_REQ = 3'd1,
    TRIG_RSP = 3'd2,
    READ_REQ = 3'd3,
    READ_RSP = 3'd4,
    RESP     = 3'd5
  } state_e;

  // Byte offsets of the PRNG slave registers relative to its base address.
  localparam logic [31:0] CTRL_OFFSET  = 32'h0000_0000;
  localparam logic [31:0] RDATA_OFFSET = 32'h0000_0004;

  // Every access is a full-word access.
  localparam logic [3:0] OBI_BE_ALL = 4'hF;

  // Default OBI ID width of the subordinate-side bus configuration.
  localparam int unsigned SBR_OBI_ID_W = 1;

endpackage

// File: rtl/prng_arbiter_rr.sv
// Round-robin arbiter.
// Picks the first set bit of req at an index >= ptr, wrapping from NUM_REQ-1
// back to 0. Purely combinational.
//   req     in  NUM_REQ  request vector
//   ptr     in  IDX_W    index with highest priority this cycle
//   gnt     out NUM_REQ  one-hot grant (all zero when no request)
//   idx     out IDX_W    index of the granted bit (0 when no request)
//   any_gnt out 1        at least one request present
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               any_gnt
);

  always_comb begin
    int cand;
    gnt     = '0;
    idx     = '0;
    any_gnt = 1'b0;
    cand    = 0;
    // Walk the requesters starting at ptr; the first hit wins.
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      cand = int'(ptr) + i;
      if (cand >= int'(NUM_REQ)) begin
        cand = cand - int'(NUM_REQ);
      end
      if (!any_gnt && req[cand]) begin
        any_gnt = 1'b1;
        idx     = IDX_W'(cand);
      end
    end
    if (any_gnt) begin
      gnt[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/prng_arbiter.sv
// Shares one memory-mapped xorshift PRNG slave between NUM_REQ requesters.
// A draw is a trigger write to CTRL followed by a read of RDATA over OBI; the
// result is handed back to the round-robin winner with a one-cycle valid pulse.
//   clk_i         in  1             clock, rising edge
//   rst_i         in  1             asynchronous active-high reset
//   req_i         in  NUM_REQ       level requests, held until granted
//   gnt_o         out NUM_REQ       one-hot grant pulse (combinational in IDLE)
//   valid_o       out NUM_REQ       one-hot result pulse
//   prn_o         out PRNG_WIDTH    random number, qualified by valid_o
//   err_o         out 1             slave error, qualified by valid_o
//   busy_o        out 1             a draw is in progress
//   obi_*_o       out               OBI manager request channel
//   obi_*_i       in                OBI manager response channel (rid ignored)
module prng_arbiter
  import prng_arb_pkg::*;
#(
  parameter int unsigned              NUM_REQ      = 4,
  parameter int unsigned              PRNG_WIDTH   = 32,
  parameter logic [31:0]              BASE_ADDR    = 32'h0000_0000,
  parameter int unsigned              ID_WIDTH_OBI = SBR_OBI_ID_W,
  parameter logic [ID_WIDTH_OBI-1:0]  AID          = '0
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NUM_REQ-1:0]      req_i,
  output logic [NUM_REQ-1:0]      gnt_o,
  output logic [NUM_REQ-1:0]      valid_o,
  output logic [PRNG_WIDTH-1:0]   prn_o,
  output logic                    err_o,
  output logic                    busy_o,
  output logic                    obi_req_o,
  output logic                    obi_we_o,
  output logic [3:0]              obi_be_o,
  output logic [31:0]             obi_addr_o,
  output logic [31:0]             obi_wdata_o,
  output logic [ID_WIDTH_OBI-1:0] obi_aid_o,
  input  logic                    obi_gnt_i,
  input  logic                    obi_rvalid_i,
  input  logic                    obi_err_i,
  input  logic [31:0]             obi_rdata_i,
  input  logic [ID_WIDTH_OBI-1:0] obi_rid_i
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        rr_q;
  logic [IDX_W-1:0]        winner_q;
  logic [PRNG_WIDTH-1:0]   data_q;
  logic                    err_q;

  logic [NUM_REQ-1:0]      arb_gnt;
  logic [IDX_W-1:0]        arb_idx;
  logic                    arb_any;

  // Response ID and rdata bits above PRNG_WIDTH carry no information here.
  logic unused_rsp;
  assign unused_rsp = ^{obi_rid_i, obi_rdata_i};

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req     (req_i),
    .ptr     (rr_q),
    .gnt     (arb_gnt),
    .idx     (arb_idx),
    .any_gnt (arb_any)
  );

  assign busy_o    = (state_q != IDLE);
  assign obi_aid_o = AID;

  always_comb begin
    state_d     = state_q;
    gnt_o       = '0;
    valid_o     = '0;
    prn_o       = '0;
    err_o       = 1'b0;
    obi_req_o   = 1'b0;
    obi_we_o    = 1'b0;
    obi_be_o    = '0;
    obi_addr_o  = '0;
    obi_wdata_o = '0;
    unique case (state_q)
      IDLE: begin
        // Grant is suppressed while reset is held so every output reads 0.
        if (arb_any && !rst_i) begin
          gnt_o   = arb_gnt;
          state_d = TRIG_REQ;
        end
      end
      TRIG_REQ: begin
        obi_req_o   = 1'b1;
        obi_we_o    = 1'b1;
        obi_be_o    = OBI_BE_ALL;
        obi_addr_o  = BASE_ADDR + CTRL_OFFSET;
        obi_wdata_o = '0;
        if (obi_gnt_i) begin
          state_d = TRIG_RSP;
        end
      end
      TRIG_RSP: begin
        if (obi_rvalid_i) begin
          state_d = obi_err_i ? RESP : READ_REQ;
        end
      end
      READ_REQ: begin
        obi_req_o  = 1'b1;
        obi_we_o   = 1'b0;
        obi_be_o   = OBI_BE_ALL;
        obi_addr_o = BASE_ADDR + RDATA_OFFSET;
        if (obi_gnt_i) begin
          state_d = READ_RSP;
        end
      end
      READ_RSP: begin
        if (obi_rvalid_i) begin
          state_d = RESP;
        end
      end
      RESP: begin
        valid_o[winner_q] = 1'b1;
        prn_o             = err_q ? '0 : data_q;
        err_o             = err_q;
        state_d           = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      rr_q     <= '0;
      winner_q <= '0;
      data_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (arb_any) begin
            winner_q <= arb_idx;
          end
        end
        TRIG_RSP: begin
          if (obi_rvalid_i) begin
            err_q <= obi_err_i;
          end
        end
        READ_RSP: begin
          if (obi_rvalid_i) begin
            data_q <= obi_rdata_i[PRNG_WIDTH-1:0];
            err_q  <= obi_err_i;
          end
        end
        RESP: begin
          err_q <= 1'b0;
          // Priority moves just past the requester that was served.
          if (winner_q == IDX_W'(NUM_REQ - 1)) begin
            rr_q <= '0;
          end else begin
            rr_q <= winner_q + IDX_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prng_arbiter.sv
module tb_prng_arbiter;

  localparam int unsigned NUM_REQ    = 4;
  localparam int unsigned PRNG_WIDTH = 32;
  localparam logic [31:0] BASE_ADDR  = 32'h1000_0100;
  localparam int unsigned ID_W       = prng_arb_pkg::SBR_OBI_ID_W;

  logic                  clk_i = 1'b0;
  logic                  rst_i = 1'b1;
  logic [NUM_REQ-1:0]    req_i = '0;
  logic [NUM_REQ-1:0]    gnt_o;
  logic [NUM_REQ-1:0]    valid_o;
  logic [PRNG_WIDTH-1:0] prn_o;
  logic                  err_o;
  logic                  busy_o;
  logic                  obi_req_o;
  logic                  obi_we_o;
  logic [3:0]            obi_be_o;
  logic [31:0]           obi_addr_o;
  logic [31:0]           obi_wdata_o;
  logic [ID_W-1:0]       obi_aid_o;
  logic                  obi_gnt_i;
  logic                  obi_rvalid_i = 1'b0;
  logic                  obi_err_i    = 1'b0;
  logic [31:0]           obi_rdata_i  = '0;
  logic [ID_W-1:0]       obi_rid_i    = '0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_i = ~clk_i;

  prng_arbiter #(
    .NUM_REQ      (NUM_REQ),
    .PRNG_WIDTH   (PRNG_WIDTH),
    .BASE_ADDR    (BASE_ADDR),
    .ID_WIDTH_OBI (ID_W),
    .AID          ('0)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_i        (req_i),
    .gnt_o        (gnt_o),
    .valid_o      (valid_o),
    .prn_o        (prn_o),
    .err_o        (err_o),
    .busy_o       (busy_o),
    .obi_req_o    (obi_req_o),
    .obi_we_o     (obi_we_o),
    .obi_be_o     (obi_be_o),
    .obi_addr_o   (obi_addr_o),
    .obi_wdata_o  (obi_wdata_o),
    .obi_aid_o    (obi_aid_o),
    .obi_gnt_i    (obi_gnt_i),
    .obi_rvalid_i (obi_rvalid_i),
    .obi_err_i    (obi_err_i),
    .obi_rdata_i  (obi_rdata_i),
    .obi_rid_i    (obi_rid_i)
  );

  // Golden xorshift32 (13, 17, 5) step.
  function automatic logic [31:0] xorshift32(input logic [31:0] x);
    logic [31:0] y;
    y = x;
    y = y ^ (y << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

  // PRNG slave responder: trigger write advances the state, RDATA read returns it.
  int          trig_delay  = 0;
  bit          trig_err    = 1'b0;
  int          wait_cnt    = 0;
  int          rd_cnt      = 0;
  int          trig_cycles = 0;
  logic [31:0] slv_state   = 32'hDEADBEEF;

  assign obi_gnt_i = obi_req_o && (!obi_we_o || (wait_cnt >= trig_delay));

  always @(posedge clk_i) begin
    obi_rvalid_i <= 1'b0;
    obi_err_i    <= 1'b0;
    obi_rdata_i  <= '0;
    if (obi_req_o && obi_we_o) trig_cycles <= trig_cycles + 1;
    if (obi_req_o && !obi_gnt_i) wait_cnt <= wait_cnt + 1;
    else                         wait_cnt <= 0;
    if (obi_req_o && obi_gnt_i) begin
      obi_rvalid_i <= 1'b1;
      if (obi_we_o) begin
        if (trig_err) obi_err_i <= 1'b1;
        else          slv_state <= xorshift32(slv_state);
      end else begin
        obi_rdata_i <= slv_state;
        rd_cnt      <= rd_cnt + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_ctl"}, 64'({gnt_o, valid_o, err_o, busy_o, obi_req_o, obi_we_o, obi_be_o}), 64'd0);
    check({tag, "_prn"}, 64'(prn_o), 64'd0);
    check({tag, "_addr"}, 64'({obi_addr_o, obi_wdata_o}), 64'd0);
    check({tag, "_aid"}, 64'(obi_aid_o), 64'd0);
  endtask

  // mode 0: release req on valid, 1: keep req held, 2: release right after grant.
  // Called and returns at a negedge with the DUT in IDLE.
  task automatic draw(input string tag, input logic [3:0] mask, input logic [3:0] exp_gnt,
                      input int mode, input int exp_lat, input logic [31:0] exp_prn,
                      input logic exp_err);
    int lat;
    bit seen;
    lat  = 0;
    seen = 1'b0;
    req_i = mask;
    #1;
    check({tag, "_gnt"}, 64'(gnt_o), 64'(exp_gnt));
    for (int c = 1; c <= 20 && !seen; c++) begin
      @(negedge clk_i);
      if (c == 1) begin
        if (mode == 2) req_i = '0;
        check({tag, "_busy"}, 64'(busy_o), 64'd1);
        check({tag, "_nognt"}, 64'(gnt_o), 64'd0);
      end
      if (obi_req_o) begin
        check({tag, "_addr"}, 64'(obi_addr_o),
              64'(obi_we_o ? BASE_ADDR : BASE_ADDR + 32'h4));
        check({tag, "_be"}, 64'(obi_be_o), 64'hF);
        if (obi_we_o) check({tag, "_wdata"}, 64'(obi_wdata_o), 64'd0);
      end
      if (valid_o != '0) begin
        seen = 1'b1;
        lat  = c;
      end
    end
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_valid"}, 64'(valid_o), 64'(exp_gnt));
    check({tag, "_prn"}, 64'(prn_o), 64'(exp_prn));
    check({tag, "_err"}, 64'(err_o), 64'(exp_err));
    if (mode != 1) req_i = '0;
    @(negedge clk_i);
  endtask

  logic [31:0] exp_state;
  int          snap;

  initial begin
    exp_state = 32'hDEADBEEF;

    // Reset state
    repeat (3) @(negedge clk_i);
    check_quiet("reset");
    rst_i = 1'b0;
    @(negedge clk_i);

    // Single requester, zero-wait slave
    exp_state = xorshift32(exp_state);
    check("golden_first", 64'(exp_state), 64'(xorshift32(32'hDEADBEEF)));
    draw("single", 4'b0001, 4'b0001, 0, 5, exp_state, 1'b0);

    // Fresh pointer, all requesting: order 0,1,2,3,0
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      logic [3:0] g;
      g = 4'b0001 << (k % 4);
      exp_state = xorshift32(exp_state);
      draw($sformatf("rr%0d", k), 4'b1111, g, (k == 4) ? 0 : 1, 5, exp_state, 1'b0);
    end

    // Trigger grant delayed by 3 cycles; pointer now 1
    trig_delay = 3;
    snap = trig_cycles;
    exp_state = xorshift32(exp_state);
    draw("delay", 4'b0010, 4'b0010, 0, 8, exp_state, 1'b0);
    check("delay_trig_cycles", 64'(trig_cycles - snap), 64'd4);
    trig_delay = 0;

    // Slave error on trigger: no read, err reported, prn 0
    trig_err = 1'b1;
    snap = rd_cnt;
    draw("err", 4'b0100, 4'b0100, 0, 3, 32'h0, 1'b1);
    check("err_no_read", 64'(rd_cnt - snap), 64'd0);
    trig_err = 1'b0;

    // Request pulsed only for the grant cycle; pointer 3 wraps to index 2
    exp_state = xorshift32(exp_state);
    draw("pulse", 4'b0100, 4'b0100, 2, 5, exp_state, 1'b0);

    // Reset while waiting for the read response
    req_i = 4'b0010;
    #1;
    check("rstmid_gnt", 64'(gnt_o), 64'b0010);
    repeat (4) @(negedge clk_i);
    req_i = '0;
    check("rstmid_busy", 64'(busy_o), 64'd1);
    exp_state = xorshift32(exp_state);
    rst_i = 1'b1;
    #1;
    check_quiet("rstmid_now");
    @(negedge clk_i);
    check_quiet("rstmid_edge");
    rst_i = 1'b0;
    @(negedge clk_i);
    check("rstmid_novalid", 64'(valid_o), 64'd0);
    // Pointer back at 0: 4'b1001 must go to requester 0, not 3
    exp_state = xorshift32(exp_state);
    draw("after_rst", 4'b1001, 4'b0001, 0, 5, exp_state, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/prng_arbiter.md
PRNG_ARBITER -- requirements
Module: prng_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters sharing one xorshift PRNG slave (range 2..8).
REQ-002 SHALL have parameter PRNG_WIDTH, default 32: width of returned random number; equals slave data width.
REQ-003 SHALL have parameter BASE_ADDR, default 32'h0000_0000: byte base of the PRNG slave; CTRL at BASE_ADDR+0x0, RDATA at BASE_ADDR+0x4.
REQ-004 SHALL have parameter ID_WIDTH_OBI, default SbrObiCfg.IdWidth: OBI ID width.
REQ-005 SHALL have parameter AID, default '0: constant OBI transaction ID driven on every request.
REQ-006 clk_i  in  1  single clock; all state on rising edge.
REQ-007 rst_i  in  1  asynchronous, active-high reset.
REQ-008 req_i  in  NUM_REQ  per-requester draw request, level; held until gnt_o bit seen.
REQ-009 gnt_o  out  NUM_REQ  one-hot, one-cycle pulse: request accepted.
REQ-010 valid_o  out  NUM_REQ  one-hot, one-cycle pulse: prn_o/err_o valid for that requester.
REQ-011 prn_o  out  PRNG_WIDTH  random number, valid only with valid_o.
REQ-012 err_o  out  1  draw failed (slave error), qualified by valid_o.
REQ-013 busy_o  out  1  high whenever FSM not in IDLE.
REQ-014 obi_req_o, obi_we_o (1), obi_be_o (4), obi_addr_o (32), obi_wdata_o (32), obi_aid_o (ID_WIDTH_OBI)  out  OBI manager request to PRNG slave.
REQ-015 obi_gnt_i, obi_rvalid_i, obi_err_i (1), obi_rdata_i (32), obi_rid_i (ID_WIDTH_OBI)  in  OBI manager response; obi_rid_i ignored.

Function
REQ-016 FSM states SHALL be IDLE, TRIG_REQ, TRIG_RSP, READ_REQ, READ_RSP, RESP.
REQ-017 IDLE: if any req_i bit set, SHALL select winner round-robin starting at pointer rr_q, pulse gnt_o[winner] same cycle (combinational), latch winner, go TRIG_REQ.
REQ-018 Round-robin: winner = first set req_i bit at index >= rr_q, wrapping from NUM_REQ-1 to 0; rr_q <= winner+1 (mod NUM_REQ) on leaving RESP.
REQ-019 TRIG_REQ: obi_req_o=1, obi_we_o=1, obi_be_o=4'hF, obi_addr_o=BASE_ADDR, obi_wdata_o=0; hold until obi_gnt_i, then TRIG_RSP.
REQ-020 TRIG_RSP: wait obi_rvalid_i; if obi_err_i set err flag and go RESP, else go READ_REQ.
REQ-021 READ_REQ: obi_req_o=1, obi_we_o=0, obi_be_o=4'hF, obi_addr_o=BASE_ADDR+4; hold until obi_gnt_i, then READ_RSP.
REQ-022 READ_RSP: on obi_rvalid_i latch obi_rdata_i[PRNG_WIDTH-1:0] and obi_err_i, go RESP.
REQ-023 RESP: valid_o[winner]=1 one cycle, prn_o=latched data (0 if err), err_o=err flag; go IDLE; err flag cleared.
REQ-024 obi_req_o SHALL be 0 in all other states; request fields SHALL stay stable while obi_req_o=1 and obi_gnt_i=0.
REQ-025 At most one OBI transaction outstanding; no new gnt_o while busy_o=1; requests arriving while busy wait.
REQ-026 Latency with zero-wait slave (gnt same cycle, rvalid next cycle): gnt_o at cycle 0, valid_o at cycle 5.
REQ-027 Deasserting req_i after gnt_o SHALL NOT abort the draw; valid_o still delivered.
REQ-028 Simultaneous obi_gnt_i and obi_rvalid_i in TRIG_REQ/READ_REQ: rvalid ignored (not expected from slave).

Reset
REQ-029 rst_i SHALL force IDLE, rr_q=0, latched winner/data/err=0 immediately; all outputs 0 (obi_aid_o=AID).
REQ-030 Reset mid-draw SHALL drop the draw without valid_o; no recovery of outstanding OBI response.

Structure
REQ-031 Package prng_arb_pkg SHALL hold state enum, CTRL/RDATA offsets (0x0/0x4) and OBI be constant.
REQ-032 Sub-module rr_arbiter (NUM_REQ-wide, pointer input, one-hot grant + index output) SHALL implement REQ-018.

Verification
REQ-033 Reset, req_i=4'b0001, zero-wait slave -> gnt_o=0001 cycle 0, valid_o=0001 cycle 5, prn_o = one xorshift32 (13,17,5) step of 32'hDEADBEEF per golden model.
REQ-034 req_i=4'b1111 held -> grant order 0,1,2,3,0; each prn_o equals successive golden xorshift32 outputs.
REQ-035 Slave gnt delayed 3 cycles on TRIG_REQ -> obi_addr_o/obi_we_o stable throughout; valid_o at cycle 8.
REQ-036 obi_err_i=1 on trigger rvalid -> no read issued, valid_o with err_o=1, prn_o=0.
REQ-037 rst_i asserted in READ_RSP -> all outputs 0 next edge, no valid_o; next draw from req_i[0] granted (rr_q=0).
REQ-038 req_i[2] pulsed for grant cycle only -> valid_o[2] still pulses 5 cycles later.
